// File: rtl/alu_cmd_queue_if.sv
// Handshake and ALU-side bundle for the ALU command queue.
// The slave modport is the queue; the master modport is its environment.
interface alu_cmd_queue_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_a;
    logic [3:0]    in_b;
    logic [3:0]    in_sel;
    logic [3:0]    a;
    logic [3:0]    b;
    logic [3:0]    sel;
    logic [7:0]    y;
    logic          out_valid;
    logic          out_ready;
    logic [7:0]    out_y;
    logic [3:0]    out_sel;
    logic [CW-1:0] count;

    modport master (
        output in_valid, in_a, in_b, in_sel, y, out_ready,
        input  in_ready, a, b, sel, out_valid, out_y, out_sel, count
    );

    modport slave (
        input  in_valid, in_a, in_b, in_sel, y, out_ready,
        output in_ready, a, b, sel, out_valid, out_y, out_sel, count
    );
endinterface

// File: rtl/alu_cmd_queue.sv
// Command FIFO feeding an external combinational ALU, with a one-deep
// result register and IDLE/EXEC/DONE sequencing.
module alu_cmd_queue #(
    parameter int DEPTH = 4
) (
    input logic            clk,
    input logic            rst_n,
    alu_cmd_queue_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] sel;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } state_t;

    state_t        state;
    state_t        state_nx;
    cmd_t          mem [DEPTH];
    cmd_t          head;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          not_full;
    logic          push;
    logic          pop;
    logic          cap;
    logic          clr;

    // Ready depends on occupancy alone: a same-cycle pop never frees a slot.
    assign not_full     = (count != CW'(DEPTH));
    assign push         = bus.in_valid && not_full;
    assign head         = mem[rd_ptr];
    assign bus.in_ready = not_full;
    assign bus.count    = count;

    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        cap      = 1'b0;
        clr      = 1'b0;
        unique case (state)
            IDLE: begin
                if (count != '0) begin
                    pop      = 1'b1;
                    state_nx = EXEC;
                end
            end
            EXEC: begin
                cap      = 1'b1;
                state_nx = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    clr = 1'b1;
                    if (count != '0) begin
                        pop      = 1'b1;
                        state_nx = EXEC;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{a: bus.in_a, b: bus.in_b, sel: bus.in_sel};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.a   <= '0;
            bus.b   <= '0;
            bus.sel <= '0;
        end else if (pop) begin
            bus.a   <= head.a;
            bus.b   <= head.b;
            bus.sel <= head.sel;
        end
    end

    // y is sampled one cycle after the operands load, so it has settled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_y     <= '0;
            bus.out_sel   <= '0;
            bus.out_valid <= 1'b0;
        end else if (cap) begin
            bus.out_y     <= bus.y;
            bus.out_sel   <= bus.sel;
            bus.out_valid <= 1'b1;
        end else if (clr) begin
            bus.out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_cmd_queue.sv
// Self-checking bench for alu_cmd_queue: directed scenarios with literal
// expectations plus randomized traffic against a queue-based model.
module tb_alu_cmd_queue;
    localparam int DEPTH = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    alu_cmd_queue_if #(.DEPTH(DEPTH)) bus ();

    alu_cmd_queue #(.DEPTH(DEPTH)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] alu(logic [3:0] a, logic [3:0] b,
                                       logic [3:0] s);
        logic signed [7:0] sa;
        logic signed [7:0] sb;
        logic [7:0] r;
        sa = {{4{a[3]}}, a};
        sb = {{4{b[3]}}, b};
        r  = 8'h00;
        if (!s[3]) begin
            case (s[2:0])
                3'd0: r = sa + sb;
                3'd1: r = sa - sb;
                3'd2: r = sb - sa;
                3'd3: r = sa + 8'sd1;
                3'd4: r = sa - 8'sd1;
                3'd5: r = -sa;
                3'd6: r = sa >>> 1;
                default: r = sa * sb;
            endcase
        end else begin
            case (s[2:0])
                3'd0: r = {4'h0, a & b};
                3'd1: r = {4'h0, a | b};
                3'd2: r = {4'h0, a ^ b};
                3'd3: r = {4'h0, ~(a & b)};
                3'd4: r = {4'h0, ~a};
                3'd5: r = {7'h0, a == b};
                3'd6: r = {7'h0, sa < sb};
                default: r = {7'h0, a < b};
            endcase
        end
        return r;
    endfunction

    assign bus.y = alu(bus.a, bus.b, bus.sel);

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    // Reference model: queue of pending commands plus result phase.
    logic [11:0] mq[$];
    int          mst = 0;
    logic [3:0]  ma = '0, mb = '0, msel = '0, mos = '0;
    logic [7:0]  my = '0;
    logic        mov = 1'b0;
    logic        mpush;
    logic [11:0] mhead;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            mst  = 0;
            ma   = '0;
            mb   = '0;
            msel = '0;
            mos  = '0;
            my   = '0;
            mov  = 1'b0;
        end else begin
            mpush = bus.in_valid && (mq.size() < DEPTH);
            case (mst)
                0: if (mq.size() > 0) begin
                    mhead = mq.pop_front();
                    {ma, mb, msel} = mhead;
                    mst = 1;
                end
                1: begin
                    my  = alu(ma, mb, msel);
                    mos = msel;
                    mov = 1'b1;
                    mst = 2;
                end
                default: if (bus.out_ready) begin
                    mov = 1'b0;
                    if (mq.size() > 0) begin
                        mhead = mq.pop_front();
                        {ma, mb, msel} = mhead;
                        mst = 1;
                    end else begin
                        mst = 0;
                    end
                end
            endcase
            if (mpush) mq.push_back({bus.in_a, bus.in_b, bus.in_sel});
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("count", 32'(bus.count), 32'(mq.size()));
            chk("in_ready", 32'(bus.in_ready), 32'(mq.size() != DEPTH));
            chk("out_valid", 32'(bus.out_valid), 32'(mov));
            chk("out_y", 32'(bus.out_y), 32'(my));
            chk("out_sel", 32'(bus.out_sel), 32'(mos));
            chk("abs", 32'({bus.a, bus.b, bus.sel}), 32'({ma, mb, msel}));
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(logic [3:0] a, logic [3:0] b, logic [3:0] s);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_sel   = s;
    endtask

    task automatic drain();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (14) step();
    endtask

    task automatic wait_valid(string n);
        int k;
        k = 0;
        while (!bus.out_valid && k < 20) begin
            step();
            k++;
        end
        if (!bus.out_valid) chk(n, 32'(bus.out_valid), 32'd1);
    endtask

    initial begin
        logic seen;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_sel    = '0;
        bus.out_ready = 1'b0;
        repeat (3) step();
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_out_y", 32'(bus.out_y), 32'd0);
        chk("rst_abs", 32'({bus.a, bus.b, bus.sel}), 32'd0);
        rst_n = 1'b1;

        // single op latency
        bus.out_ready = 1'b1;
        drive(4'd3, 4'd2, 4'd0);
        step();
        bus.in_valid = 1'b0;
        step();
        chk("lat_e1_valid", 32'(bus.out_valid), 32'd0);
        step();
        chk("lat_e2_valid", 32'(bus.out_valid), 32'd1);
        chk("single_y", 32'(bus.out_y), 32'h05);
        chk("single_sel", 32'(bus.out_sel), 32'h0);
        step();
        chk("single_held1", 32'(bus.out_valid), 32'd0);
        drain();

        // ordering under backpressure
        bus.out_ready = 1'b0;
        drive(4'hD, 4'd2, 4'd7);
        step();
        drive(4'd1, 4'd4, 4'd1);
        step();
        bus.in_valid = 1'b0;
        step();
        chk("bp_valid", 32'(bus.out_valid), 32'd1);
        chk("bp_y0", 32'(bus.out_y), 32'hFA);
        repeat (3) step();
        chk("bp_y0_hold", 32'(bus.out_y), 32'hFA);
        bus.out_ready = 1'b1;
        step();
        wait_valid("bp_timeout");
        chk("bp_y1", 32'(bus.out_y), 32'hFD);
        drain();

        // fill to full
        bus.out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive(4'(i), 4'd1, 4'd0);
            step();
            if (i == 4) begin
                chk("full_count", 32'(bus.count), 32'd4);
                chk("full_ready", 32'(bus.in_ready), 32'd0);
            end
        end
        chk("full_no_6th", 32'(bus.count), 32'd4);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wait_valid("full_timeout");
            chk("full_order", 32'(bus.out_y), 32'(k + 1));
            step();
        end
        drain();

        // simultaneous push and pop at count 2
        bus.out_ready = 1'b0;
        drive(4'd1, 4'd1, 4'd0);
        step();
        drive(4'd2, 4'd1, 4'd0);
        step();
        drive(4'd3, 4'd1, 4'd0);
        step();
        chk("pp_count_pre", 32'(bus.count), 32'd2);
        drive(4'd4, 4'd1, 4'd0);
        bus.out_ready = 1'b1;
        step();
        chk("pp_count", 32'(bus.count), 32'd2);
        drain();

        // reset while a result is pending
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(4'(i + 2), 4'd3, 4'd1);
            step();
        end
        bus.in_valid = 1'b0;
        chk("mid_count", 32'(bus.count), 32'd3);
        chk("mid_valid", 32'(bus.out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.out_valid), 32'd0);
        chk("arst_count", 32'(bus.count), 32'd0);
        chk("arst_ready", 32'(bus.in_ready), 32'd1);
        step();
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            step();
            seen = seen | bus.out_valid;
        end
        chk("no_stale", 32'(seen), 32'd0);

        // logic op
        drive(4'b1010, 4'b0110, 4'b1110);
        step();
        bus.in_valid = 1'b0;
        wait_valid("logic_timeout");
        chk("logic_y", 32'(bus.out_y), 32'h01);
        chk("logic_sel", 32'(bus.out_sel), 32'hE);
        drain();

        // randomized traffic with varying pressure
        for (int blk = 0; blk < 6; blk++) begin
            for (int c = 0; c < 300; c++) begin
                bus.in_valid  = ($urandom_range(0, 3) < (blk % 3) + 1);
                bus.in_a      = 4'($urandom);
                bus.in_b      = 4'($urandom);
                bus.in_sel    = 4'($urandom);
                bus.out_ready = ($urandom_range(0, 3) >= (blk % 2) * 2);
                step();
            end
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_cmd_queue.md
ALU_CMD_QUEUE -- requirements
Module: alu_cmd_queue

Interface
REQ-001 Parameter: DEPTH, 4, command FIFO entries; power of two, minimum 2.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  upstream command valid.
REQ-005 in_ready  output  1  queue can accept a command (FIFO not full).
REQ-006 in_a  input  4  signed operand A of the command.
REQ-007 in_b  input  4  signed operand B of the command.
REQ-008 in_sel  input  4  ALU opcode of the command (bit 3 = logic/arith select).
REQ-009 a  output  4  registered operand A driven to ALU.
REQ-010 b  output  4  registered operand B driven to ALU.
REQ-011 sel  output  4  registered opcode driven to ALU.
REQ-012 y  input  8  signed combinational ALU result for current a/b/sel.
REQ-013 out_valid  output  1  result register holds an unconsumed result.
REQ-014 out_ready  input  1  downstream accepts result.
REQ-015 out_y  output  8  captured signed ALU result.
REQ-016 out_sel  output  4  opcode that produced out_y.
REQ-017 count  output  3  FIFO occupancy, 0..DEPTH (width clog2(DEPTH)+1).

Function
REQ-018 Push: in_valid && in_ready at a rising edge writes {in_a,in_b,in_sel} at write pointer; pointer increments modulo DEPTH.
REQ-019 in_ready = (count != DEPTH), combinational from count only; no bypass into a full FIFO, even if a pop occurs the same cycle.
REQ-020 FSM states IDLE, EXEC, DONE; encoding left to implementer.
REQ-021 IDLE: if count != 0, pop head into a/b/sel registers and go EXEC; else stay IDLE, a/b/sel hold.
REQ-022 EXEC: capture y into out_y and sel into out_sel, set out_valid, go DONE; lasts exactly one cycle.
REQ-023 DONE: out_valid=1, out_y/out_sel stable; while out_ready=0 stay DONE.
REQ-024 DONE with out_ready=1: clear out_valid; if count != 0 pop head into a/b/sel and go EXEC same edge, else go IDLE.
REQ-025 Latency: command pushed into empty queue at edge E0 in IDLE -> popped at E1 -> out_valid high after E2.
REQ-026 Throughput: one result per 2 cycles with out_ready held high.
REQ-027 Pop reads the read pointer and increments it modulo DEPTH; no pop when count == 0.
REQ-028 Simultaneous push and pop: both occur; count unchanged; data ordering strictly FIFO.
REQ-029 count +1 on push only, -1 on pop only, unchanged otherwise.
REQ-030 out_y is y stored unmodified (8-bit two's complement); no sign or width conversion in this block.
REQ-031 in_* ignored when in_valid=0; out_ready ignored outside DONE.

Reset
REQ-032 rst_n=0 asynchronously forces: state IDLE, both pointers 0, count 0, a/b/sel 0, out_y 0, out_sel 0, out_valid 0; in_ready therefore 1.
REQ-033 Reset mid-operation discards all queued commands and any pending result; no result is emitted for them after release.
REQ-034 FIFO storage contents need not be reset.
REQ-035 After rst_n deasserts, first push accepted on the next rising edge.

Verification
REQ-036 Single op: push a=3,b=2,sel=0 into empty queue, out_ready=1 -> out_valid after 2nd following edge, out_y=5, out_sel=0, held one cycle.
REQ-037 Ordering/backpressure: push (a=-3,b=2,sel=7) then (a=1,b=4,sel=1) with out_ready=0 -> out_y=-6 (8'hFA) held stable; after out_ready=1, next result out_y=-3 (8'hFD).
REQ-038 Full: out_ready=0, push 5 commands back-to-back -> first popped, count reaches 4, in_ready=0, 6th in_valid not accepted; released results appear in push order.
REQ-039 Simultaneous push/pop at count=2 -> count stays 2; pointer wrap after 8 total pushes preserves order.
REQ-040 Reset mid-DONE with count=3 -> out_valid=0, count=0, in_ready=1 immediately, no stale result after release.
REQ-041 Logic op: push a=4'b1010,b=4'b0110,sel=4'b1110 -> out_y equals ALU y for that op (8'h01 for the 1-bit logic path), out_sel=4'hE.
